// File: rtl/pio_poll_master.sv
// Avalon-MM master that programs a PIO slave's IRQ mask and polls
// its data register on interrupt or timer, buffering samples in a FIFO.
module pio_poll_master #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [1:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        irq_in,
   input  logic [31:0] cfg_mask,
   input  logic        cfg_load,
   input  logic [15:0] cfg_period,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  fifo_level,
   output logic        overflow,
   input  logic        overflow_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      MASK_WR,
      IDLE,
      RD_ISSUE,
      RD_WAIT
   } state_t;

   state_t          r_state;
   logic            r_pend_load;
   logic            r_pend_tick;
   logic [15:0]     r_cnt;
   logic [31:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [4:0]      r_level;
   logic            r_overflow;

   logic            w_tick;
   logic            w_full;
   logic            w_pop;
   logic            w_capture;
   logic            w_push;
   logic            w_drop;
   logic            w_go_mask;
   logic            w_go_rd;

   assign w_tick    = (cfg_period != 16'd0) &&
                      (r_cnt == cfg_period - 16'd1);
   assign w_full    = (r_level == 5'(FIFO_DEPTH));
   assign w_pop     = out_valid & out_ready;
   assign w_capture = (r_state == RD_WAIT);
   assign w_push    = w_capture & (~w_full | w_pop);
   assign w_drop    = w_capture & w_full & ~w_pop;
   assign w_go_mask = (r_state == IDLE) & r_pend_load;
   assign w_go_rd   = (r_state == IDLE) & ~r_pend_load &
                      (r_pend_tick | (irq_in & ~w_full));

   assign out_valid  = (r_level != 5'd0);
   assign out_data   = out_valid ? r_mem[r_rd_ptr] : 32'd0;
   assign fifo_level = r_level;
   assign overflow   = r_overflow;

   // Bus sequencer: state plus registered Avalon outputs for the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_address    <= 2'd0;
         avm_writedata  <= 32'd0;
      end else begin
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_address    <= 2'd0;
         avm_writedata  <= 32'd0;
         unique case (r_state)
            IDLE: begin
               if (w_go_mask) begin
                  r_state        <= MASK_WR;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  avm_address    <= 2'd2;
                  avm_writedata  <= cfg_mask;
               end else if (w_go_rd) begin
                  r_state        <= RD_ISSUE;
                  avm_chipselect <= 1'b1;
               end
            end
            MASK_WR:  r_state <= IDLE;
            RD_ISSUE: r_state <= RD_WAIT;
            RD_WAIT:  r_state <= IDLE;
         endcase
      end
   end

   // Pending requests; a new request on the same edge as entry wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_load <= 1'b1;
         r_pend_tick <= 1'b0;
      end else begin
         if (cfg_load)
            r_pend_load <= 1'b1;
         else if (w_go_mask)
            r_pend_load <= 1'b0;
         if (w_tick)
            r_pend_tick <= 1'b1;
         else if (w_go_rd)
            r_pend_tick <= 1'b0;
      end
   end

   // Free-running poll timer; out-of-range counts snap back to zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= 16'd0;
      else if (cfg_period == 16'd0 || r_cnt >= cfg_period - 16'd1)
         r_cnt <= 16'd0;
      else
         r_cnt <= r_cnt + 16'd1;
   end

   // Sample storage; contents need no reset since out_data is gated.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= avm_readdata;
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= 5'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_level <= r_level + 5'd1;
         else if (!w_push && w_pop)
            r_level <= r_level - 5'd1;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (overflow_clr)
            r_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: directed vector table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_pio_poll_master;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = 32'd0;
   logic        irq_in = 1'b0;
   logic [31:0] cfg_mask = 32'h0000_00F0;
   logic        cfg_load = 1'b0;
   logic [15:0] cfg_period = 16'd0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  fifo_level;
   logic        overflow;
   logic        overflow_clr = 1'b0;

   int n_tests = 0;
   int n_fail = 0;

   pio_poll_master #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .avm_address(avm_address),
      .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n),
      .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata),
      .irq_in(irq_in),
      .cfg_mask(cfg_mask),
      .cfg_load(cfg_load),
      .cfg_period(cfg_period),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .fifo_level(fifo_level),
      .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // The bus is a queue of pending bus cycles; empty queue = idle.
   localparam int K_MASK = 1;
   localparam int K_RDA  = 2;
   localparam int K_RDW  = 3;

   typedef struct {
      int          k;
      logic [31:0] wd;
   } op_t;

   op_t         sq[$];
   logic [31:0] fq[$];
   bit          m_pl;
   bit          m_pt;
   bit          m_ovf;
   int          m_cnt;

   function automatic void model_reset();
      sq.delete();
      fq.delete();
      m_pl  = 1'b1;
      m_pt  = 1'b0;
      m_ovf = 1'b0;
      m_cnt = 0;
   endfunction

   function automatic void model_step();
      bit pop, rdw, drop, smask, srd, tick;
      int p;
      p     = int'(cfg_period);
      pop   = (fq.size() > 0) && out_ready;
      rdw   = (sq.size() > 0) && (sq[0].k == K_RDW);
      drop  = 1'b0;
      smask = 1'b0;
      srd   = 1'b0;
      if (sq.size() == 0) begin
         if (m_pl)
            smask = 1'b1;
         else if (m_pt)
            srd = 1'b1;
         else if (irq_in && fq.size() < DEPTH)
            srd = 1'b1;
      end else begin
         void'(sq.pop_front());
      end
      if (pop)
         void'(fq.pop_front());
      if (rdw) begin
         if (fq.size() < DEPTH)
            fq.push_back(avm_readdata);
         else
            drop = 1'b1;
      end
      if (smask)
         sq.push_back('{K_MASK, cfg_mask});
      if (srd) begin
         sq.push_back('{K_RDA, 32'd0});
         sq.push_back('{K_RDW, 32'd0});
      end
      tick  = (p != 0) && (m_cnt == p - 1);
      m_cnt = (p == 0 || m_cnt >= p - 1) ? 0 : m_cnt + 1;
      if (cfg_load)
         m_pl = 1'b1;
      else if (smask)
         m_pl = 1'b0;
      if (tick)
         m_pt = 1'b1;
      else if (srd)
         m_pt = 1'b0;
      if (drop)
         m_ovf = 1'b1;
      else if (overflow_clr)
         m_ovf = 1'b0;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [127:0] a,
                      input logic [127:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   function automatic logic [127:0] act_vec();
      return {avm_chipselect, avm_write_n, avm_address,
              avm_writedata, out_valid,
              (out_valid ? out_data : 32'd0),
              fifo_level, overflow};
   endfunction

   function automatic logic [127:0] mdl_vec();
      logic       cs, wn;
      logic [1:0] ad;
      logic [31:0] wd, hd;
      cs = 1'b0; wn = 1'b1; ad = 2'd0; wd = 32'd0;
      if (sq.size() > 0 && sq[0].k == K_MASK) begin
         cs = 1'b1; wn = 1'b0; ad = 2'd2; wd = sq[0].wd;
      end else if (sq.size() > 0 && sq[0].k == K_RDA) begin
         cs = 1'b1;
      end
      hd = (fq.size() > 0) ? fq[0] : 32'd0;
      return {cs, wn, ad, wd, (fq.size() > 0), hd,
              5'(fq.size()), m_ovf};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("model", act_vec(), mdl_vec());
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus", {avm_chipselect, avm_write_n, avm_address,
                      avm_writedata}, {1'b0, 1'b1, 2'd0, 32'd0});
      chk("rst_out", {out_valid, out_data, fifo_level, overflow},
          {1'b0, 32'd0, 5'd0, 1'b0});
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        irq;
      logic        load;
      logic        rdy;
      logic [31:0] rd;
      logic        cs;
      logic        wn;
      logic [1:0]  ad;
      logic [31:0] wd;
      logic        v;
      logic [31:0] d;
      logic [4:0]  lvl;
   } vec_t;

   vec_t tv[14];

   initial begin
      int rd_t[$];
      int c;
      bit found;

      tv[0]  = '{0, 0, 0, 32'h0, 1, 0, 2, 32'hF0, 0, 32'h0, 0};
      tv[1]  = '{0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0};
      tv[2]  = '{1, 0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0, 0};
      tv[3]  = '{0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0};
      tv[4]  = '{0, 0, 0, 32'h12345678, 0, 1, 0, 32'h0,
                 1, 32'h12345678, 1};
      tv[5]  = '{0, 1, 0, 32'h0, 0, 1, 0, 32'h0,
                 1, 32'h12345678, 1};
      tv[6]  = '{0, 0, 0, 32'h0, 1, 0, 2, 32'hF0,
                 1, 32'h12345678, 1};
      tv[7]  = '{0, 0, 1, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0};
      tv[8]  = '{1, 0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0, 0};
      tv[9]  = '{1, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0};
      tv[10] = '{1, 0, 0, 32'hAAAA0001, 0, 1, 0, 32'h0,
                 1, 32'hAAAA0001, 1};
      tv[11] = '{1, 0, 0, 32'h0, 1, 1, 0, 32'h0,
                 1, 32'hAAAA0001, 1};
      tv[12] = '{0, 0, 0, 32'h0, 0, 1, 0, 32'h0,
                 1, 32'hAAAA0001, 1};
      tv[13] = '{0, 0, 0, 32'hBBBB0002, 0, 1, 0, 32'h0,
                 1, 32'hAAAA0001, 2};

      // Mask write after reset, irq read latency, load, irq repeat.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         irq_in       = tv[i].irq;
         cfg_load     = tv[i].load;
         out_ready    = tv[i].rdy;
         avm_readdata = tv[i].rd;
         cycle();
         chk($sformatf("vec%0d", i),
             {avm_chipselect, avm_write_n, avm_address,
              avm_writedata, out_valid,
              (out_valid ? out_data : 32'd0), fifo_level},
             {tv[i].cs, tv[i].wn, tv[i].ad, tv[i].wd, tv[i].v,
              tv[i].d, tv[i].lvl});
      end
      irq_in = 0; cfg_load = 0; out_ready = 0; avm_readdata = 0;

      // Periodic polling fills FIFO, fifth sample drops.
      do_reset();
      cfg_period = 16'd10;
      c = 0;
      while (rd_t.size() < 4 && c < 200) begin
         avm_readdata = 32'hC000_0000 + c;
         cycle();
         c++;
         if (avm_chipselect && avm_write_n)
            rd_t.push_back(c);
      end
      repeat (2) cycle();
      chk("per_lvl4", {fifo_level, overflow}, {5'd4, 1'b0});
      if (rd_t.size() >= 2)
         chk("per_gap", 32'(rd_t[1] - rd_t[0]), 32'd10);
      else
         chk("per_gap", 32'(rd_t.size()), 32'd2);
      while (rd_t.size() < 5 && c < 300) begin
         avm_readdata = 32'hC000_0000 + c;
         cycle();
         c++;
         if (avm_chipselect && avm_write_n)
            rd_t.push_back(c);
      end
      repeat (2) cycle();
      chk("drop_ovf", {fifo_level, overflow}, {5'd4, 1'b1});
      overflow_clr = 1'b1;
      cycle();
      overflow_clr = 1'b0;
      chk("ovf_clr", {27'd0, overflow}, 28'd0);

      // Full FIFO with a pop on the push cycle: no drop.
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (avm_chipselect && avm_write_n)
            found = 1;
      end
      chk("wait_rd6", {31'd0, found}, 32'd1);
      cycle();
      out_ready = 1'b1;
      avm_readdata = 32'h5A5A_0006;
      cycle();
      out_ready = 1'b0;
      cfg_period = 16'd0;
      chk("full_pp", {fifo_level, overflow}, {5'd4, 1'b0});
      out_ready = 1'b1;
      for (int i = 0; i < 8 && fifo_level != 0; i++) begin
         if (fifo_level == 5'd1)
            chk("last_out", out_data, 32'h5A5A_0006);
         cycle();
      end
      out_ready = 1'b0;
      chk("drained", {27'd0, fifo_level}, 32'd0);

      // Load and tick pending together: mask write first.
      do_reset();
      cycle();
      cycle();
      cfg_period = 16'd4;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (sq.size() == 0 && m_cnt == 3 && !m_pt && !m_pl)
            found = 1;
         else
            cycle();
      end
      chk("wait_tick", {31'd0, found}, 32'd1);
      cfg_load = 1'b1;
      cycle();
      cfg_load = 1'b0;
      chk("lt_idle", {avm_chipselect, avm_write_n}, {1'b0, 1'b1});
      cycle();
      chk("lt_mask", {avm_chipselect, avm_write_n, avm_address},
          {1'b1, 1'b0, 2'd2});
      cycle();
      chk("lt_idle2", {avm_chipselect, avm_write_n}, {1'b0, 1'b1});
      cycle();
      chk("lt_rd", {avm_chipselect, avm_write_n, avm_address},
          {1'b1, 1'b1, 2'd0});
      cfg_period = 16'd0;

      // Reset in the middle of a read abandons it.
      do_reset();
      cycle();
      irq_in = 1'b1;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (avm_chipselect && avm_write_n)
            found = 1;
      end
      chk("wait_iss", {31'd0, found}, 32'd1);
      irq_in = 1'b0;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst", {avm_chipselect, out_valid, fifo_level},
          {1'b0, 1'b0, 5'd0});
      @(negedge clk);
      reset_n = 1'b1;
      cycle();
      chk("rst_mask", {avm_chipselect, avm_write_n, avm_address},
          {1'b1, 1'b0, 2'd2});
      repeat (3) cycle();
      chk("no_push", {27'd0, fifo_level}, 32'd0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            case ($urandom_range(0, 5))
               0: cfg_period = 16'd0;
               1: cfg_period = 16'd1;
               2: cfg_period = 16'd3;
               3: cfg_period = 16'd7;
               4: cfg_period = 16'd12;
               default: cfg_period = 16'd5;
            endcase
            cfg_mask = $urandom;
         end
         irq_in       = ($urandom_range(0, 3) != 0);
         cfg_load     = ($urandom_range(0, 49) == 0);
         out_ready    = ($urandom_range(0, 2) == 0);
         overflow_clr = ($urandom_range(0, 39) == 0);
         avm_readdata = $urandom;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pio_poll_master.md
PIO_POLL_MASTER -- requirements
Module: pio_poll_master

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning result FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 avm_address  output  2  Avalon-MM word address to the PIO slave.
REQ-005 avm_chipselect  output  1  Avalon-MM select.
REQ-006 avm_write_n  output  1  Avalon-MM write strobe, active-low.
REQ-007 avm_writedata  output  32  Avalon-MM write data.
REQ-008 avm_readdata  input  32  Avalon-MM read data; fixed read latency of 1 cycle.
REQ-009 irq_in  input  1  level interrupt from the PIO slave.
REQ-010 cfg_mask  input  32  IRQ mask value to program into slave address 2.
REQ-011 cfg_load  input  1  single-cycle pulse; request a mask write.
REQ-012 cfg_period  input  16  periodic-poll interval in cycles; 0 disables periodic polling.
REQ-013 out_data  output  32  FIFO head sample.
REQ-014 out_valid  output  1  FIFO non-empty.
REQ-015 out_ready  input  1  consumer accepts; a pop occurs when out_valid and out_ready are both 1.
REQ-016 fifo_level  output  5  current FIFO occupancy.
REQ-017 overflow  output  1  sticky; set when a sample is dropped.
REQ-018 overflow_clr  input  1  clears overflow.

Function
REQ-019 The FSM SHALL have the states MASK_WR, IDLE, RD_ISSUE and RD_WAIT.
REQ-020 In IDLE, RD_WAIT and the reset state, outputs SHALL be: avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
REQ-021 MASK_WR SHALL last 1 cycle and drive avm_chipselect=1, avm_write_n=0, avm_address=2 and avm_writedata=cfg_mask; it then goes to IDLE.
REQ-022 RD_ISSUE SHALL last 1 cycle and drive avm_chipselect=1, avm_write_n=1, avm_address=0; it then goes to RD_WAIT.
REQ-023 RD_WAIT SHALL last 1 cycle, capture avm_readdata, and push it to the FIFO on the edge leaving RD_WAIT; it then goes to IDLE.
REQ-024 Read latency SHALL be: trigger seen in IDLE at cycle T -> RD_ISSUE at T+1 -> RD_WAIT at T+2; if the FIFO was empty, out_valid=1 and out_data equals the sample at T+3.
REQ-025 A cfg_load pulse in any state SHALL set a pending_load flag; the flag clears on entry to MASK_WR.
REQ-026 IDLE priority SHALL be: pending_load -> MASK_WR; else pending_tick -> RD_ISSUE; else (irq_in=1 and FIFO not full) -> RD_ISSUE; else stay in IDLE.
REQ-027 The period counter SHALL be 16 bits, count every cycle in every state while cfg_period != 0, and wrap to 0 on reaching cfg_period-1, setting pending_tick.
REQ-028 If the count is >= cfg_period (for example after cfg_period is reduced), the counter SHALL reset to 0 next cycle.
REQ-029 When cfg_period == 0, the counter SHALL be held at 0 and no tick SHALL be generated.
REQ-030 pending_tick SHALL clear on entry to RD_ISSUE; a tick arriving while pending_tick is already set SHALL be merged and not counted twice.
REQ-031 When irq_in stays high, irq-triggered reads SHALL repeat at most once per 3 cycles and SHALL be suppressed while the FIFO is full.
REQ-032 A tick-triggered read SHALL always be issued; if the FIFO is full at push time with no simultaneous pop, the sample SHALL be dropped and overflow set.
REQ-033 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full; fifo_level SHALL then be unchanged.
REQ-034 A pop on an empty FIFO SHALL be impossible (out_valid=0); out_data SHALL be don't-care when out_valid=0.
REQ-035 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range from 0 to FIFO_DEPTH.
REQ-036 If overflow_clr and a drop occur in the same cycle, overflow SHALL remain 1.

Reset
REQ-037 On reset_n=0, the block SHALL clear the FSM, FIFO (level 0), pointers, period counter, pending flags and overflow.
REQ-038 On reset_n=0, out_valid SHALL be 0, out_data SHALL be 0, and the bus outputs SHALL take their idle values.
REQ-039 The first state after reset release SHALL be MASK_WR (pending_load treated as set), so the slave mask is always reprogrammed.
REQ-040 Reset asserted mid-read SHALL abandon the read; no push SHALL occur.

Verification
REQ-041 Reset release, cfg_mask=0x0000_00F0 -> one cycle of chipselect=1, write_n=0, address=2, writedata=0x0000_00F0, then IDLE.
REQ-042 irq_in=1 pulse, readdata=0x1234_5678 at the RD_WAIT cycle, out_ready=0 -> out_valid=1 and out_data=0x1234_5678 three cycles after the trigger, fifo_level=1.
REQ-043 cfg_period=10, irq_in=0, out_ready=0 -> a read every 10 cycles; after 4 samples fifo_level=4 and the 5th sample drops with overflow=1; overflow_clr -> overflow=0.
REQ-044 FIFO full, out_ready=1 during the push cycle -> no drop, fifo_level stays 4, samples emerge in order.
REQ-045 cfg_load and tick pending together in IDLE -> MASK_WR first, then RD_ISSUE on the next IDLE.
REQ-046 reset_n dropped during RD_ISSUE -> no push, fifo_level=0, and MASK_WR follows reset release.
